// File: rtl/axil_mem_slave_pkg.sv
// Shared AXI4-Lite response codes, channel FSM states and the address range check
// used by the memory responder.
package axil_pkg;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_HAVE_A = 2'd1,
        W_HAVE_D = 2'd2,
        W_RESP   = 2'd3
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rstate_t;

    // Byte address maps to a word index; anything at or beyond DEPTH words is out of range.
    function automatic logic in_range(input logic [31:0] addr, input int depth);
        return ({2'b00, addr[31:2]} < $unsigned(depth));
    endfunction

endpackage

// File: rtl/axil_mem_slave_if.sv
// AXI4-Lite bus bundle between a load/store master and the memory responder.
interface axil_mem_slave_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_ram_core.sv
// Word-organised RAM with one byte-enabled write port and one registered read port;
// a read and a write to the same word on one edge return the old contents.
module axil_ram_core #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       wstrb_i,
    input  logic             re_i,
    input  logic             rok_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Byte-lane write port; contents survive reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read register loads only on an accepted read and returns zero for out-of-range words
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'h0000_0000;
        end else if (re_i) begin
            rdata_q <= rok_i ? mem_q[raddr_i] : 32'h0000_0000;
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/axil_mem_slave.sv
// AXI4-Lite memory responder: independent write and read channels, one outstanding
// transaction each, out-of-range accesses answered with SLVERR.
module axil_mem_slave
    import axil_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32
) (
    input logic              clk,
    input logic              reset,
    axil_mem_slave_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DATA_W != 32) begin : g_bad_data_w
        $error("axil_mem_slave supports DATA_W = 32 only");
    end

    wstate_t           w_state_q, w_state_d;
    rstate_t           r_state_q, r_state_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d;
    logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
    logic              aw_hs_s, w_hs_s, ar_hs_s, commit_s, cm_ok_s, ar_ok_s;
    logic [ADDR_W-1:0] cm_addr_s;
    logic [31:0]       cm_data_s, ram_rdata_s;
    logic [3:0]        cm_strb_s;

    assign aw_hs_s   = bus.awvalid & awready_q;
    assign w_hs_s    = bus.wvalid & wready_q;
    assign ar_hs_s   = bus.arvalid & arready_q;
    // The commit uses whichever half arrives on this edge, the other half from its capture register
    assign cm_addr_s = aw_hs_s ? bus.awaddr : awaddr_q;
    assign cm_data_s = w_hs_s ? bus.wdata : wdata_q;
    assign cm_strb_s = w_hs_s ? bus.wstrb : wstrb_q;
    assign cm_ok_s   = in_range(32'(cm_addr_s), DEPTH);
    assign ar_ok_s   = in_range(32'(bus.araddr), DEPTH);

    // Write channel next state, captures and registered handshake outputs
    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        commit_s  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    w_state_d = W_RESP;
                    commit_s  = 1'b1;
                end else if (aw_hs_s) begin
                    w_state_d = W_HAVE_A;
                    awaddr_d  = bus.awaddr;
                end else if (w_hs_s) begin
                    w_state_d = W_HAVE_D;
                    wdata_d   = bus.wdata;
                    wstrb_d   = bus.wstrb;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_HAVE_A: begin
                if (w_hs_s) begin
                    w_state_d = W_RESP;
                    commit_s  = 1'b1;
                end else begin
                    w_state_d = W_HAVE_A;
                end
            end
            W_HAVE_D: begin
                if (aw_hs_s) begin
                    w_state_d = W_RESP;
                    commit_s  = 1'b1;
                end else begin
                    w_state_d = W_HAVE_D;
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (commit_s) begin
            bresp_d = cm_ok_s ? AXI_OKAY : AXI_SLVERR;
        end else begin
            bresp_d = bresp_q;
        end
        awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_D);
        wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_A);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Read channel next state and registered handshake outputs
    always_comb begin
        r_state_d = r_state_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_state_d = R_RESP;
                    rresp_d   = ar_ok_s ? AXI_OKAY : AXI_SLVERR;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_RESP: begin
                if (bus.rready) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_state_d = R_RESP;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_RESP);
    end

    // State and output registers; readies stay low until the first edge after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= 32'h0000_0000;
            wstrb_q   <= 4'h0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
        end
    end

    axil_ram_core #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (commit_s & cm_ok_s),
        .waddr_i (IDX_W'(cm_addr_s[ADDR_W-1:2])),
        .wdata_i (cm_data_s),
        .wstrb_i (cm_strb_s),
        .re_i    (ar_hs_s),
        .rok_i   (ar_ok_s),
        .raddr_i (IDX_W'(bus.araddr[ADDR_W-1:2])),
        .rdata_o (ram_rdata_s)
    );

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = ram_rdata_s;
endmodule
